// File: rtl/snake_draw_pkg.sv
// Shared constants for the snake draw engine: opcodes, command fields,
// register map, FSM state type and palette reset contents.
package snake_draw_pkg;

  localparam logic [3:0] OP_FILL  = 4'h1;
  localparam logic [3:0] OP_CLEAR = 4'h2;
  localparam logic [3:0] OP_ABORT = 4'hF;

  localparam int OP_LSB  = 28;
  localparam int COL_LSB = 26;
  localparam int CX_LSB  = 16;
  localparam int CY_LSB  = 6;
  localparam int CMD_W   = 32 - CY_LSB;

  localparam logic [3:0] ADDR_CMD    = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_ERRCLR = 4'd2;
  localparam logic [3:0] ADDR_PAL0   = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2
  } draw_state_t;

  localparam logic [3:0][15:0] PAL_RST = {16'hF800, 16'h07E0, 16'hFFFF, 16'h0000};

endpackage

// File: rtl/draw_cmd_fifo.sv
// Command FIFO with show-ahead read; flush overrides push and pop.
module draw_cmd_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 26
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == (AW+1)'(FIFO_DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/snake_draw_engine.sv
// Queued cell/screen fill engine: host slave feeds a command FIFO, the FSM
// streams one pixel write per accepted master beat.
//   state   | meaning
//   ST_IDLE | waiting for a queued command
//   ST_LOAD | pop and decode one command, latch extents and colour
//   ST_DRAW | stream pixel writes, x fastest, until last beat or abort
module snake_draw_engine
  import snake_draw_pkg::*;
#(
  parameter int          X_PIXELS   = 320,
  parameter int          Y_PIXELS   = 240,
  parameter int          CELL       = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] PX_BASE    = 32'h0800_0000,
  parameter int          Y_SHIFT    = 10,
  parameter int          X_SHIFT    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  hps_address,
  input  logic        hps_write,
  input  logic [31:0] hps_writedata,
  input  logic        hps_read,
  output logic [31:0] hps_readdata,
  output logic        hps_waitrequest,
  output logic [31:0] vga_px_address,
  output logic        vga_px_write,
  output logic [15:0] vga_px_writedata,
  input  logic        vga_px_waitrequest,
  output logic [6:0]  state_export
);

  localparam int          LW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] CELL16 = 16'(CELL);
  localparam logic [15:0] X_CELLS = 16'(X_PIXELS / CELL);
  localparam logic [15:0] Y_CELLS = 16'(Y_PIXELS / CELL);
  localparam logic [15:0] X_END  = 16'(X_PIXELS - 1);
  localparam logic [15:0] Y_END  = 16'(Y_PIXELS - 1);

  draw_state_t      r_state, w_state_nx;
  logic [3:0][15:0] r_pal;
  logic [15:0]      r_colour;
  logic [15:0]      r_px, r_py, r_px0, r_px_end, r_py_end;
  logic             r_abort_pend;
  logic             r_stall_q;
  logic             r_ovf_err, r_rng_err;

  logic             w_cmd_sel, w_abort, w_push_req;
  logic             w_full, w_empty;
  logic [LW-1:0]    w_level;
  logic [CMD_W-1:0] w_cmd;
  logic [3:0]       w_op;
  logic [1:0]       w_col;
  logic [15:0]      w_cx, w_cy, w_cx_px, w_cy_px;
  logic             w_fill_ok, w_draw_cmd, w_draw, w_last, w_busy, w_load_go;

  assign w_cmd_sel       = hps_write && (hps_address == ADDR_CMD);
  assign w_abort         = w_cmd_sel && (hps_writedata[OP_LSB +: 4] == OP_ABORT);
  assign w_push_req      = w_cmd_sel && !w_abort;
  assign hps_waitrequest = w_push_req && w_full;

  draw_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (w_push_req && !w_full),
    .pop   (r_state == ST_LOAD),
    .flush (w_abort),
    .wdata (hps_writedata[31:CY_LSB]),
    .rdata (w_cmd),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // Stored word drops the unused low bits, so field offsets shift by CY_LSB.
  assign w_op       = w_cmd[OP_LSB-CY_LSB +: 4];
  assign w_col      = w_cmd[COL_LSB-CY_LSB +: 2];
  assign w_cx       = {6'd0, w_cmd[CX_LSB-CY_LSB +: 10]};
  assign w_cy       = {6'd0, w_cmd[0 +: 10]};
  assign w_cx_px    = w_cx * CELL16;
  assign w_cy_px    = w_cy * CELL16;
  assign w_fill_ok  = (w_cx < X_CELLS) && (w_cy < Y_CELLS);
  assign w_draw_cmd = ((w_op == OP_FILL) && w_fill_ok) || (w_op == OP_CLEAR);
  assign w_load_go  = (r_state == ST_LOAD) && !w_abort;

  assign w_draw = (r_state == ST_DRAW);
  assign w_last = (r_px == r_px_end) && (r_py == r_py_end);
  assign w_busy = (r_state != ST_IDLE) || !w_empty;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty && !w_abort) w_state_nx = ST_LOAD;
      ST_LOAD: w_state_nx = (!w_abort && w_draw_cmd) ? ST_DRAW : ST_IDLE;
      ST_DRAW: begin
        if (!vga_px_waitrequest && (w_abort || r_abort_pend || w_last))
          w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pal        <= PAL_RST;
      r_colour     <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_px0        <= '0;
      r_px_end     <= '0;
      r_py_end     <= '0;
      r_abort_pend <= 1'b0;
      r_stall_q    <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_rng_err    <= 1'b0;
    end else begin
      if (hps_write && (hps_address[3:2] == ADDR_PAL0[3:2]))
        r_pal[hps_address[1:0]] <= hps_writedata[15:0];

      if (w_load_go) begin
        r_colour <= r_pal[w_col];
        if (w_op == OP_CLEAR) begin
          r_px     <= '0;
          r_px0    <= '0;
          r_py     <= '0;
          r_px_end <= X_END;
          r_py_end <= Y_END;
        end else begin
          r_px     <= w_cx_px;
          r_px0    <= w_cx_px;
          r_py     <= w_cy_px;
          r_px_end <= w_cx_px + CELL16 - 16'd1;
          r_py_end <= w_cy_px + CELL16 - 16'd1;
        end
        if ((w_op == OP_FILL) && !w_fill_ok) r_rng_err <= 1'b1;
      end else if (w_draw && !vga_px_waitrequest && !w_last) begin
        if (r_px == r_px_end) begin
          r_px <= r_px0;
          r_py <= r_py + 16'd1;
        end else begin
          r_px <= r_px + 16'd1;
        end
      end

      r_abort_pend <= w_draw && (w_abort || r_abort_pend) && (w_state_nx == ST_DRAW);

      // A stalled push that the host gives up on is lost.
      r_stall_q <= hps_waitrequest;
      if (r_stall_q && !hps_write) r_ovf_err <= 1'b1;

      if (hps_write && (hps_address == ADDR_ERRCLR)) begin
        r_ovf_err <= 1'b0;
        r_rng_err <= 1'b0;
      end
    end
  end

  assign vga_px_write     = w_draw;
  assign vga_px_address   = w_draw ? (PX_BASE | (32'(r_py) << Y_SHIFT) | (32'(r_px) << X_SHIFT)) : 32'd0;
  assign vga_px_writedata = w_draw ? r_colour : 16'd0;
  assign hps_readdata     = (hps_read && (hps_address == ADDR_STATUS)) ?
                            {r_ovf_err, r_rng_err, w_busy, 21'd0, 8'(w_level)} : 32'd0;
  assign state_export     = {5'd0, r_state};

endmodule

// File: tb/tb_snake_draw_engine.sv
// Scoreboard bench for snake_draw_engine on a reduced 64x32 screen.
module tb_snake_draw_engine;

  localparam int XP   = 64;
  localparam int YP   = 32;
  localparam int CELL = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  hps_address;
  logic        hps_write;
  logic [31:0] hps_writedata;
  logic        hps_read;
  logic [31:0] hps_readdata;
  logic        hps_waitrequest;
  logic [31:0] vga_px_address;
  logic        vga_px_write;
  logic [15:0] vga_px_writedata;
  logic        vga_px_waitrequest;
  logic [6:0]  state_export;

  always #5 clk = ~clk;

  snake_draw_engine #(
    .X_PIXELS(XP), .Y_PIXELS(YP), .CELL(CELL), .FIFO_DEPTH(8),
    .PX_BASE(32'h0800_0000), .Y_SHIFT(10), .X_SHIFT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .hps_address(hps_address), .hps_write(hps_write), .hps_writedata(hps_writedata),
    .hps_read(hps_read), .hps_readdata(hps_readdata), .hps_waitrequest(hps_waitrequest),
    .vga_px_address(vga_px_address), .vga_px_write(vga_px_write),
    .vga_px_writedata(vga_px_writedata), .vga_px_waitrequest(vga_px_waitrequest),
    .state_export(state_export)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wr_mode  = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int mark     = 0;
  int first_cyc, last_cyc;
  logic [31:0] first_addr, last_addr;
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] px_addr(input int x, input int y);
    return 32'h0800_0000 | (32'(y) << 10) | (32'(x) << 1);
  endfunction

  function automatic logic [31:0] cmd(input logic [3:0] op, input logic [1:0] col,
                                      input int cx, input int cy);
    return {op, col, 10'(cx), 10'(cy), 6'd0};
  endfunction

  task automatic push_fill_exp(input int cx, input int cy, input logic [15:0] c);
    for (int y = cy*CELL; y < cy*CELL + CELL; y++)
      for (int x = cx*CELL; x < cx*CELL + CELL; x++)
        exp_q.push_back({px_addr(x, y), c});
  endtask

  task automatic push_clear_exp(input logic [15:0] c);
    for (int y = 0; y < YP; y++)
      for (int x = 0; x < XP; x++)
        exp_q.push_back({px_addr(x, y), c});
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    case (wr_mode)
      1:       vga_px_waitrequest = 1'($urandom_range(0, 1));
      2:       vga_px_waitrequest = 1'b1;
      default: vga_px_waitrequest = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset_n && vga_px_write && !vga_px_waitrequest) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("px_addr", vga_px_address, mon_e[47:16]);
        check("px_data", {16'd0, vga_px_writedata}, {16'd0, mon_e[15:0]});
      end
      if (n_acc == mark) begin
        first_cyc  = cyc;
        first_addr = vga_px_address;
      end
      last_cyc  = cyc;
      last_addr = vga_px_address;
      n_acc++;
    end
  end

  task automatic hps_wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    hps_address = a; hps_writedata = d; hps_write = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!hps_waitrequest) break;
    end
    check("hps_wr_accept", 32'(hps_waitrequest), 32'd0);
    @(posedge clk); #1;
    hps_write = 1'b0;
  endtask

  task automatic hps_rd(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    hps_address = a; hps_read = 1'b1;
    @(negedge clk);
    d = hps_readdata;
    @(posedge clk); #1;
    hps_read = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < 20000; i++) begin
      hps_rd(4'd1, s);
      if (!s[29]) break;
    end
    check("idle_busy", 32'(s[29]), 32'd0);
  endtask

  task automatic wait_write();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vga_px_write) break;
    end
    check("wait_write", 32'(vga_px_write), 32'd1);
  endtask

  logic [31:0] s;
  int          mark2;

  initial begin
    reset_n = 1'b0; hps_address = '0; hps_write = 1'b0; hps_writedata = '0;
    hps_read = 1'b0; vga_px_waitrequest = 1'b0;
    repeat (3) @(posedge clk); #1;
    hps_read = 1'b1; hps_address = 4'd1; #1;
    check("rst_write", 32'(vga_px_write), 32'd0);
    check("rst_addr", vga_px_address, 32'd0);
    check("rst_data", 32'(vga_px_writedata), 32'd0);
    check("rst_state", 32'(state_export), 32'd0);
    check("rst_status", hps_readdata, 32'd0);
    hps_read = 1'b0;
    reset_n = 1'b1;

    // Palette 2 reset value, cell (3,5), no stall: back-to-back beats.
    wr_mode = 0; mark = n_acc;
    push_fill_exp(3, 5, 16'h07E0);
    hps_wr(4'd0, cmd(4'h1, 2'd2, 3, 5));
    wait_idle();
    check("t1_count", 32'(n_acc - mark), 32'd16);
    check("t1_first", first_addr, 32'h0800_5018);
    check("t1_last", last_addr, 32'h0800_5C1E);
    check("t1_span", 32'(last_cyc - first_cyc), 32'd15);

    // Written palette, last valid cell, random stalls.
    hps_wr(4'd5, 32'h0000_1234);
    wr_mode = 1; mark = n_acc;
    push_fill_exp(15, 7, 16'h1234);
    hps_wr(4'd0, cmd(4'h1, 2'd1, 15, 7));
    push_fill_exp(0, 0, 16'hF800);
    hps_wr(4'd0, cmd(4'h1, 2'd3, 0, 0));
    push_fill_exp(1, 0, 16'h0000);
    hps_wr(4'd0, cmd(4'h1, 2'd0, 1, 0));
    hps_wr(4'd0, cmd(4'h7, 2'd0, 2, 0));
    wait_idle();
    check("t2_count", 32'(n_acc - mark), 32'd48);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-range cells are dropped and flag range_err.
    mark = n_acc;
    hps_wr(4'd0, cmd(4'h1, 2'd1, 80, 0));
    hps_wr(4'd0, cmd(4'h1, 2'd1, 16, 0));
    hps_wr(4'd0, cmd(4'h1, 2'd1, 0, 8));
    wait_idle();
    hps_rd(4'd1, s);
    check("rng_set", 32'(s[31:30]), 32'd1);
    check("rng_no_write", 32'(n_acc - mark), 32'd0);
    hps_wr(4'd2, 32'd0);
    hps_rd(4'd1, s);
    check("rng_clear", s, 32'd0);
    hps_rd(4'd3, s);
    check("other_read", s, 32'd0);

    // Full-screen clear with random stalls.
    mark = n_acc;
    push_clear_exp(16'h1234);
    hps_wr(4'd0, cmd(4'h2, 2'd1, 0, 0));
    wait_idle();
    check("clr_count", 32'(n_acc - mark), 32'(XP*YP));
    check("clr_sb_empty", 32'(exp_q.size()), 32'd0);

    // FIFO fill while drawing is stalled; ninth queued push stalls until a pop.
    wr_mode = 2; mark = n_acc;
    push_clear_exp(16'h0000);
    hps_wr(4'd0, cmd(4'h2, 2'd0, 0, 0));
    wait_write();
    for (int i = 0; i < 8; i++) begin
      push_fill_exp(i, 1, 16'h1234);
      hps_wr(4'd0, cmd(4'h1, 2'd1, i, 1));
    end
    hps_rd(4'd1, s);
    check("full_level", 32'(s[7:0]), 32'd8);
    check("full_busy", 32'(s[29]), 32'd1);
    push_fill_exp(8, 1, 16'h1234);
    @(posedge clk); #1;
    hps_address = 4'd0; hps_writedata = cmd(4'h1, 2'd1, 8, 1); hps_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_stall", 32'(hps_waitrequest), 32'd1);
    end
    wr_mode = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!hps_waitrequest) break;
    end
    check("stall_release", 32'(hps_waitrequest), 32'd0);
    @(posedge clk); #1;
    hps_write = 1'b0;
    wait_idle();
    check("full_count", 32'(n_acc - mark), 32'(XP*YP + 9*16));
    hps_rd(4'd1, s);
    check("no_ovf", s, 32'd0);

    // Abort a clear with commands queued; also provoke overflow first.
    wr_mode = 1; mark = n_acc;
    push_clear_exp(16'h0000);
    hps_wr(4'd0, cmd(4'h2, 2'd0, 0, 0));
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_acc - mark >= 100) break;
    end
    check("ab_progress", 32'(n_acc - mark >= 100), 32'd1);
    for (int i = 0; i < 3; i++) hps_wr(4'd0, cmd(4'h1, 2'd1, i, 2));
    hps_rd(4'd1, s);
    check("ab_level3", 32'(s[7:0]), 32'd3);
    wr_mode = 2;
    repeat (4) @(posedge clk);
    for (int i = 3; i < 8; i++) hps_wr(4'd0, cmd(4'h1, 2'd1, i, 2));
    @(posedge clk); #1;
    hps_address = 4'd0; hps_writedata = cmd(4'h1, 2'd1, 9, 2); hps_write = 1'b1;
    @(negedge clk);
    check("ovf_stall", 32'(hps_waitrequest), 32'd1);
    @(posedge clk); #1;
    hps_write = 1'b0;
    repeat (2) @(posedge clk);
    hps_rd(4'd1, s);
    check("ovf_set", 32'(s[31]), 32'd1);
    check("ovf_level", 32'(s[7:0]), 32'd8);
    @(posedge clk); #1;
    hps_address = 4'd0; hps_writedata = cmd(4'hF, 2'd0, 0, 0); hps_write = 1'b1;
    @(negedge clk);
    check("abort_nostall", 32'(hps_waitrequest), 32'd0);
    @(posedge clk); #1;
    hps_write = 1'b0;
    @(negedge clk);
    check("ab_beat_held", 32'(vga_px_write), 32'd1);
    check("ab_beat_addr", vga_px_address, exp_q[0][47:16]);
    hps_rd(4'd1, s);
    check("ab_level0", 32'(s[7:0]), 32'd0);
    check("ab_busy", 32'(s[29]), 32'd1);
    mark2 = n_acc;
    wr_mode = 0;
    wait_idle();
    check("ab_one_beat", 32'(n_acc - mark2), 32'd1);
    exp_q.delete();
    repeat (20) @(posedge clk);
    check("ab_no_more", 32'(n_acc - mark2), 32'd1);
    check("ab_state", 32'(state_export), 32'd0);
    hps_wr(4'd2, 32'd0);
    hps_rd(4'd1, s);
    check("err_clear", s, 32'd0);

    // Reset mid-draw: write drops at once, palette returns to defaults.
    wr_mode = 2;
    hps_wr(4'd0, cmd(4'h1, 2'd1, 2, 2));
    wait_write();
    reset_n = 1'b0;
    #1;
    check("rstd_write", 32'(vga_px_write), 32'd0);
    hps_read = 1'b1; hps_address = 4'd1; #1;
    check("rstd_status", hps_readdata, 32'd0);
    check("rstd_state", 32'(state_export), 32'd0);
    hps_read = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    wr_mode = 0; mark = n_acc;
    push_fill_exp(2, 2, 16'hFFFF);
    hps_wr(4'd0, cmd(4'h1, 2'd1, 2, 2));
    wait_idle();
    check("rstd_count", 32'(n_acc - mark), 32'd16);
    check("rstd_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_draw_engine.md
SNAKE_DRAW_ENGINE -- requirements
Module: snake_draw_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- X_PIXELS, 320, screen width in pixels.
- Y_PIXELS, 240, screen height in pixels.
- CELL, 4, square cell edge in pixels; must divide both X_PIXELS and Y_PIXELS.
- FIFO_DEPTH, 8, command FIFO entries; power of two.
- PX_BASE, 32'h0800_0000, pixel buffer base address.
- Y_SHIFT, 10, address shift for y.
- X_SHIFT, 1, address shift for x.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- hps_address, in, 4, slave register select.
- hps_write, in, 1, slave write strobe.
- hps_writedata, in, 32, slave write data.
- hps_read, in, 1, slave read strobe.
- hps_readdata, out, 32, slave read data.
- hps_waitrequest, out, 1, slave stall.
- vga_px_address, out, 32, master address.
- vga_px_write, out, 1, master write strobe.
- vga_px_writedata, out, 16, master write data.
- vga_px_waitrequest, in, 1, master stall.
- state_export, out, 7, current FSM state, zero-extended.

Function
REQ-003 Address 0 write SHALL push hps_writedata into the command FIFO; hps_waitrequest SHALL be 1 only while address 0 is written with the FIFO full. The one exception is an ABORT word (REQ-010), which never stalls.
REQ-004 Addresses 4..7 write SHALL load palette entry [addr-4] with writedata[15:0]; address 1 read SHALL return {overflow_err[31], range_err[30], busy[29], 21'b0, fifo_level[7:0]}. Other reads SHALL return 0 with zero wait.
REQ-005 Command word fields SHALL be: op [31:28], colour index [27:26], cell x [25:16], cell y [15:6]. Opcodes:
- 1 = FILL_CELL.
- 2 = CLEAR, fills the whole screen.
- F = ABORT.
- Any other opcode SHALL be popped and ignored.
REQ-006 FSM states SHALL be IDLE, LOAD, DRAW.
- IDLE -> LOAD when the FIFO is non-empty.
- LOAD pops and decodes one entry in one cycle, then goes to DRAW, or back to IDLE if the command is ignored.
- DRAW -> IDLE on acceptance of the last pixel.
REQ-007 In DRAW, vga_px_write SHALL stay 1. Address SHALL be PX_BASE | (py << Y_SHIFT) | (px << X_SHIFT). Writedata SHALL be the palette entry latched in LOAD.
- Address and data SHALL hold while vga_px_waitrequest=1.
- The pixel counter SHALL advance one pixel per cycle with waitrequest=0.
REQ-008 Pixel order SHALL be x-fastest, then y.
- FILL_CELL spans px = cx*CELL .. cx*CELL+CELL-1 and py likewise: CELL*CELL writes.
- CLEAR spans 0..X_PIXELS-1 by 0..Y_PIXELS-1: X_PIXELS*Y_PIXELS writes.
REQ-009 FILL_CELL with cx >= X_PIXELS/CELL or cy >= Y_PIXELS/CELL SHALL be dropped in LOAD, with no bus write, and SHALL set sticky range_err.
REQ-010 ABORT SHALL be taken directly at the slave write, never queued, and SHALL never stall.
- It flushes the FIFO in the same cycle.
- If in DRAW, the engine finishes the beat in flight (waits for waitrequest=0), then returns to IDLE.
- An ABORT simultaneous with a FIFO push drops that push.
REQ-011 A write to address 0 while the FIFO is full SHALL stall (REQ-003). overflow_err SHALL set if the host deasserts hps_write while stalled.
- Address 2 write SHALL clear both sticky error bits.
- Simultaneous push and pop when full SHALL not be possible, because stall takes priority.
- Simultaneous push and pop when non-full SHALL keep the level unchanged.
REQ-012 busy SHALL equal (state != IDLE) | FIFO non-empty. vga_px_write SHALL be 0 outside DRAW.

Reset
REQ-013 reset_n low SHALL asynchronously force:
- state to IDLE;
- FIFO empty;
- error bits to 0;
- vga_px_write, vga_px_address, vga_px_writedata, hps_readdata to 0;
- palette to {0000, FFFF, 07E0, F800}.
REQ-014 Reset asserted mid-DRAW SHALL drop the current beat immediately; the bus protocol violation is accepted.

Structure
REQ-015 The package snake_draw_pkg SHALL hold the opcode constants, field offsets, the state enum, register addresses and the palette reset values.
REQ-016 The FIFO SHALL be the sub-module draw_cmd_fifo (parameter FIFO_DEPTH; ports push, pop, flush, full, empty, level).

Verification
REQ-017 FILL_CELL palette 2 at cell (3,5), waitrequest=0 -> 16 writes of 07E0 from 0x0800_5018 to 0x0800_5C1E, all in consecutive cycles.
REQ-018 CLEAR with waitrequest randomly high 50% of cycles -> exactly 76800 accepted writes, no address skipped or repeated, then busy=0.
REQ-019 Push 9 commands with DRAW stalled (waitrequest=1) -> the ninth push stalls hps_waitrequest=1 until a pop, and the status level reads 8.
REQ-020 FILL_CELL at cell (80,0) -> no vga writes, range_err=1; a write to address 2 clears it.
REQ-021 ABORT during a CLEAR with 3 commands queued -> the in-flight beat completes, then IDLE, level 0, no further writes.
REQ-022 reset_n low mid-DRAW -> vga_px_write=0 within the same cycle, the status register reads 0.
